counter_sequencer: RTL and testbench
====================================

Name: counter_sequencer

Overview:
- Controller that sequences an 8-bit up/down counter datapath. It accepts a command (start value, target, direction, auto-reload) over a valid/ready handshake.
- It steps the counter once per prescaled tick, with wrap-around, until the target is reached. It then pulses done and either returns to idle or reloads and repeats.
- It sits between a host/FSM issuing timing jobs and the shared counter resource, and supports pause and abort.

Parameters:
- WIDTH, 8, counter and command data width.
- PRESCALE, 1, clock cycles per counter step; legal values are 1 or more.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous reset, active-low (rst=0 resets immediately).
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command; combinational: (state==IDLE) & ~abort.
- cmd_start  input  WIDTH  value loaded into the counter on accept.
- cmd_target  input  WIDTH  terminal value.
- cmd_dir  input  1  1 = count up, 0 = count down.
- cmd_reload  input  1  1 = repeat the job until abort.
- pause  input  1  level; freezes the counter and prescaler while high in RUN/HOLD.
- abort  input  1  level; cancels the job.
- count_out  output  WIDTH  current counter value.
- busy  output  1  state != IDLE.
- done  output  1  registered one-cycle pulse when the target is reached.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, count_out=0, done=0, prescaler=0, latched command fields=0.
  - busy=0; cmd_ready=1 once abort=0.
  - Reset mid-job discards the job with no done pulse.
- States: IDLE, RUN, HOLD.
- IDLE:
  - A handshake occurs when cmd_valid & cmd_ready. On that edge: latch start/target/dir/reload, count_out<=cmd_start, prescaler<=0, state<=RUN.
  - With no handshake, count_out holds its value.
- Tick: asserted when state==RUN, ~pause, and prescaler==PRESCALE-1. The prescaler advances only in RUN with ~pause and wraps to 0 on a tick. With PRESCALE=1, every RUN cycle is a tick.
- RUN, on a tick:
  - If count_out==target: done<=1.
    - reload=1: count_out<=start; stay in RUN.
    - reload=0: state<=IDLE; count_out holds the target.
  - Otherwise, count_out<=count_out+1 (dir=1) or count_out-1 (dir=0), modulo 2^WIDTH. Wrap-around is legal: 255->0 up, 0->255 down.
- done is 0 on every edge without a terminal tick. For a non-reload job, done=1 in the same cycle busy first reads 0.
- Latency (PRESCALE=1): from the accept edge, done asserts after (N+1) further edges, where N = distance from start to target in the chosen direction mod 2^WIDTH. For start==target, done asserts 1 edge after accept.
- HOLD:
  - RUN & pause -> HOLD on the next edge. HOLD & ~pause -> RUN.
  - count_out and prescaler are frozen in HOLD.
  - pause high in RUN suppresses that cycle's tick, so pause beats done.
- abort (priority below reset):
  - In RUN/HOLD: next edge -> IDLE, count_out holds, prescaler<=0, no done pulse.
  - In IDLE: cmd_ready=0, so a same-cycle cmd_valid is not accepted.
- New commands are ignored while busy (cmd_ready=0). With reload=1, only abort or reset ends the job.
- Changes to cmd_* after accept have no effect.

Decomposition:
- Shared package ctrl_pkg holds:
  - state encoding constants ST_IDLE, ST_RUN, ST_HOLD (2-bit);
  - DIR_UP=1, DIR_DOWN=0.
- One sub-module: updown_counter (parameter WIDTH).
  - Ports: clk, rst (async active-low, clears to 0), load, load_val, enable, direction, count_out.
  - Priority: load > enable; holds when neither is asserted.
  - counter_sequencer instantiates it. The FSM, prescaler, compare and handshake logic stay in the top.

Test Plan:
- Reset: rst=0 mid-RUN (count 7) -> count_out=0, busy=0, done=0 immediately. After rst=1: cmd_ready=1.
- Up job, PRESCALE=1: start=3, target=5, dir=1, reload=0 -> count_out 3,4,5 on successive edges; done=1 for one cycle 3 edges after accept; busy=0 in that cycle; count_out stays 5.
- Down job with wrap-around: start=1, target=254, dir=0 -> sequence 1,0,255,254; done after 4 edges.
- Up wrap-around with PRESCALE=4: start=255, target=0, dir=1 -> 255 held for 4 cycles, then 0; done 4 cycles later.
- Reload, pause and abort: start=0, target=2, reload=1 -> done pulses every 3 cycles, busy stays 1, cmd_ready=0. Hold pause for 5 cycles at count 1 -> count frozen, state HOLD, no done. Then abort -> IDLE, count holds, no done.
- Handshake edges:
  - cmd_valid with abort=1 in IDLE -> not accepted.
  - cmd_valid while busy -> ignored.
  - start==target=9 -> done 1 edge after accept.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared constants for the counter sequencer: FSM state encoding and count direction.
package ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_HOLD = 2'd2;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/updown_counter.sv
// Loadable up/down counter with modulo-2^WIDTH wrap; load has priority over enable.
module updown_counter
  import ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             enable,
  input  logic             direction,
  output logic [WIDTH-1:0] count_out
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (enable) begin
      count_d = (direction == DIR_UP) ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out = count_q;

endmodule

// File: rtl/counter_sequencer.sv
// Sequences an up/down counter job: accept a command, step once per prescaled tick until the
// target is hit, pulse done, then go idle or reload. Supports pause (HOLD) and abort.
module counter_sequencer
  import ctrl_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_target,
  input  logic             cmd_dir,
  input  logic             cmd_reload,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PrescLast = PW'(PRESCALE - 1);

  state_t           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] start_q, target_q;
  logic             dir_q, reload_q;
  logic             done_q, done_d;

  logic             accept;
  logic             tick;
  logic             step;
  logic             at_target;
  logic             ctr_load;
  logic             ctr_enable;
  logic [WIDTH-1:0] ctr_load_val;

  assign accept    = cmd_valid & cmd_ready;
  assign tick      = (state_q == ST_RUN) & ~pause & (presc_q == PrescLast);
  // abort wins over a same-cycle tick: no step and no done pulse
  assign step      = tick & ~abort;
  assign at_target = (count_out == target_q);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (pause) begin
          state_d = ST_HOLD;
        end else if (step && at_target && !reload_q) begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (!pause) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy      = (state_q != ST_IDLE);
    cmd_ready = (state_q == ST_IDLE) & ~abort;
    done      = done_q;
  end

  always_comb begin
    presc_d = presc_q;
    if (accept || (busy && abort)) begin
      presc_d = '0;
    end else if (state_q == ST_RUN && !pause) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end
  end

  assign done_d       = step & at_target;
  assign ctr_load     = accept | (step & at_target & reload_q);
  assign ctr_load_val = accept ? cmd_start : start_q;
  assign ctr_enable   = step & ~at_target;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q  <= '0;
      start_q  <= '0;
      target_q <= '0;
      dir_q    <= 1'b0;
      reload_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      done_q  <= done_d;
      if (accept) begin
        start_q  <= cmd_start;
        target_q <= cmd_target;
        dir_q    <= cmd_dir;
        reload_q <= cmd_reload;
      end
    end
  end

  updown_counter #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (ctr_load),
    .load_val (ctr_load_val),
    .enable   (ctr_enable),
    .direction(dir_q),
    .count_out(count_out)
  );

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer: a behavioural job model queues per-cycle expectations.
module tb_counter_sequencer;
  import ctrl_pkg::*;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready, cmd_ready4;
  logic [7:0] cmd_start, cmd_target;
  logic       cmd_dir, cmd_reload;
  logic       pause, abort;
  logic [7:0] count_out, count_out4;
  logic       busy, busy4;
  logic       done, done4;

  typedef struct packed {
    logic [7:0] count;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  counter_sequencer #(.WIDTH(8), .PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_target(cmd_target), .cmd_dir(cmd_dir),
    .cmd_reload(cmd_reload), .pause(pause), .abort(abort),
    .count_out(count_out), .busy(busy), .done(done)
  );

  counter_sequencer #(.WIDTH(8), .PRESCALE(4)) dut4 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready4),
    .cmd_start(cmd_start), .cmd_target(cmd_target), .cmd_dir(cmd_dir),
    .cmd_reload(cmd_reload), .pause(pause), .abort(abort),
    .count_out(count_out4), .busy(busy4), .done(done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  // Expected {count, busy, done} for n samples, starting at the negedge after the accept edge.
  task automatic push_job(input logic [7:0] start, input logic [7:0] target, input logic dir,
                          input logic reload, input int presc, input int n);
    logic [7:0] c;
    int         p;
    logic       b, d;
    exp_t       e;
    c = start; p = 0; b = 1'b1; d = 1'b0;
    for (int i = 0; i < n; i++) begin
      e.count = c; e.busy = b; e.done = d;
      sb_q.push_back(e);
      d = 1'b0;
      if (b) begin
        if (p == presc - 1) begin
          p = 0;
          if (c == target) begin
            d = 1'b1;
            if (reload) c = start;
            else b = 1'b0;
          end else begin
            c = dir ? c + 8'd1 : c - 8'd1;
          end
        end else begin
          p++;
        end
      end
    end
  endtask

  // One-cycle handshake; scrambles cmd_* afterwards to show they no longer matter.
  task automatic accept(input logic [7:0] s, input logic [7:0] t, input logic dir,
                        input logic rl);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_start = s; cmd_target = t; cmd_dir = dir; cmd_reload = rl;
    @(posedge clk); #1;
    cmd_valid  = 1'b0;
    cmd_start  = 8'($urandom);
    cmd_target = 8'($urandom);
    cmd_dir    = 1'($urandom);
    cmd_reload = 1'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    bit found;
    @(negedge clk);
    n_cmp++;
    if ({count_out, busy, done, cmd_ready} !== {8'd0, 1'b0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_state: got count=%0d busy=%0b done=%0b ready=%0b expected 0/0/0/1",
               count_out, busy, done, cmd_ready);
    end
    accept(8'd5, 8'd20, 1'b1, 1'b0);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (count_out === 8'd7) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL reset_reach7: got count=%0d required 7 within 10 cycles", count_out);
    end
    #1 rst = 1'b0;
    #1;
    n_cmp++;
    if (count_out !== 8'd0) begin
      n_bad++; $display("FAIL reset_async_count: got %0d expected 0", count_out);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_async_busy: got %0b expected 0", busy);
    end
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++; $display("FAIL reset_async_done: got %0b expected 0", done);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({cmd_ready, busy, count_out} !== {1'b1, 1'b0, 8'd0}) begin
      n_bad++;
      $display("FAIL reset_release: got ready=%0b busy=%0b count=%0d expected 1/0/0",
               cmd_ready, busy, count_out);
    end
  endtask

  task automatic test_up();
    exp_t e;
    accept(8'd3, 8'd5, 1'b1, 1'b0);
    push_job(8'd3, 8'd5, 1'b1, 1'b0, 1, 6);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      n_cmp++;
      if ({count_out, busy, done} !== e) begin
        n_bad++;
        $display("FAIL up_job[%0d]: got count=%0d busy=%0b done=%0b expected %0d/%0b/%0b",
                 i, count_out, busy, done, e.count, e.busy, e.done);
      end
    end
  endtask

  task automatic test_down_wrap();
    exp_t e;
    accept(8'd1, 8'd254, 1'b0, 1'b0);
    push_job(8'd1, 8'd254, 1'b0, 1'b0, 1, 7);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      n_cmp++;
      if ({count_out, busy, done} !== e) begin
        n_bad++;
        $display("FAIL down_wrap[%0d]: got count=%0d busy=%0b done=%0b expected %0d/%0b/%0b",
                 i, count_out, busy, done, e.count, e.busy, e.done);
      end
    end
  endtask

  task automatic test_prescale();
    exp_t e;
    do_reset();
    accept(8'd255, 8'd0, 1'b1, 1'b0);
    push_job(8'd255, 8'd0, 1'b1, 1'b0, 4, 12);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      n_cmp++;
      if ({count_out4, busy4, done4} !== e) begin
        n_bad++;
        $display("FAIL presc4_wrap[%0d]: got count=%0d busy=%0b done=%0b expected %0d/%0b/%0b",
                 i, count_out4, busy4, done4, e.count, e.busy, e.done);
      end
    end
  endtask

  task automatic test_reload_pause_abort();
    exp_t e;
    bit   found;
    accept(8'd0, 8'd2, 1'b1, 1'b1);
    push_job(8'd0, 8'd2, 1'b1, 1'b1, 1, 7);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      n_cmp++;
      if ({count_out, busy, done, cmd_ready} !== {e, 1'b0}) begin
        n_bad++;
        $display("FAIL reload[%0d]: got count=%0d busy=%0b done=%0b ready=%0b expected %0d/%0b/%0b/0",
                 i, count_out, busy, done, cmd_ready, e.count, e.busy, e.done);
      end
    end
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (count_out === 8'd1) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++; $display("FAIL reload_reach1: got count=%0d required 1 within 10 cycles", count_out);
    end
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({count_out, busy, done} !== {8'd1, 1'b1, 1'b0}) begin
        n_bad++;
        $display("FAIL pause_freeze[%0d]: got count=%0d busy=%0b done=%0b expected 1/1/0",
                 i, count_out, busy, done);
      end
    end
    n_cmp++;
    if (dut1.state_q !== ST_HOLD) begin
      n_bad++; $display("FAIL pause_state: got %0d expected %0d", dut1.state_q, ST_HOLD);
    end
    pause = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({count_out, busy, done} !== {8'd1, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL abort_hold: got count=%0d busy=%0b done=%0b expected 1/0/0",
               count_out, busy, done);
    end
    n_cmp++;
    if (cmd_ready !== 1'b0) begin
      n_bad++; $display("FAIL abort_ready: got %0b expected 0", cmd_ready);
    end
    abort = 1'b0;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL abort_release_ready: got %0b expected 1", cmd_ready);
    end
  endtask

  task automatic test_handshake();
    exp_t e;
    // Command offered while abort is high in IDLE must be refused.
    @(negedge clk);
    abort = 1'b1; cmd_valid = 1'b1; cmd_start = 8'd77; cmd_target = 8'd80;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b0) begin
      n_bad++; $display("FAIL abort_idle_ready: got %0b expected 0", cmd_ready);
    end
    @(negedge clk);
    n_cmp++;
    if ({busy, count_out} !== {1'b0, 8'd1}) begin
      n_bad++;
      $display("FAIL abort_idle_accept: got busy=%0b count=%0d expected 0/1", busy, count_out);
    end
    cmd_valid = 1'b0; abort = 1'b0;

    // Command offered while busy must be ignored.
    accept(8'd10, 8'd12, 1'b1, 1'b0);
    push_job(8'd10, 8'd12, 1'b1, 1'b0, 1, 6);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      n_cmp++;
      if ({count_out, busy, done} !== e) begin
        n_bad++;
        $display("FAIL busy_ignore[%0d]: got count=%0d busy=%0b done=%0b expected %0d/%0b/%0b",
                 i, count_out, busy, done, e.count, e.busy, e.done);
      end
      if (i == 0) begin
        cmd_valid = 1'b1; cmd_start = 8'd100; cmd_target = 8'd100;
      end
      if (i == 2) cmd_valid = 1'b0;
    end

    accept(8'd9, 8'd9, 1'b0, 1'b0);
    push_job(8'd9, 8'd9, 1'b0, 1'b0, 1, 3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      n_cmp++;
      if ({count_out, busy, done} !== e) begin
        n_bad++;
        $display("FAIL equal_job[%0d]: got count=%0d busy=%0b done=%0b expected %0d/%0b/%0b",
                 i, count_out, busy, done, e.count, e.busy, e.done);
      end
    end
  endtask

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_start = '0; cmd_target = '0;
    cmd_dir = 1'b0; cmd_reload = 1'b0; pause = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    test_reset();
    test_up();
    test_down_wrap();
    test_prescale();
    test_reload_pause_abort();
    test_handshake();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
